// File: rtl/pmp_pkg.sv
// rtl/pmp_pkg.sv - shared types and constants for the PMP entry programmer
package pmp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WR_ADDR,
        WR_CFG,
        RESP
    } state_e;

    typedef enum logic [2:0] {
        OK    = 3'd0,
        SIZE  = 3'd1,
        ALIGN = 3'd2,
        PERM  = 3'd3,
        ENTRY = 3'd4,
        LOCK  = 3'd5,
        BUS   = 3'd6
    } err_e;

    localparam logic [11:0] PMPADDR_BASE = 12'h3B0;
    localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
    localparam logic [1:0]  A_NA4        = 2'b10;
    localparam logic [1:0]  A_NAPOT      = 2'b11;
    localparam int          MAX_ENTRIES  = 16;

    function automatic logic [7:0] cfg_byte(input logic lock, input logic [1:0] a,
                                            input logic [2:0] perm);
        return {lock, 2'b00, a, perm};
    endfunction

endpackage

// File: rtl/napot_mask_gen.sv
// rtl/napot_mask_gen.sv - log2 region size to NAPOT trailing-ones and alignment masks
module napot_mask_gen (
    input  logic [5:0]  log2sz,
    output logic [31:0] trail_mask,
    output logic [31:0] align_mask
);

    logic [5:0] trail_sh;

    // Inverting a shifted all-ones word keeps log2sz=32 exact: the shift empties the word.
    always_comb begin
        trail_sh   = (log2sz >= 6'd3) ? (log2sz - 6'd3) : 6'd0;
        align_mask = ~(32'hFFFF_FFFF << log2sz);
        trail_mask = (log2sz >= 6'd3) ? ~(32'hFFFF_FFFF << trail_sh) : 32'd0;
    end

endmodule

// File: rtl/pmp_napot_encoder.sv
// rtl/pmp_napot_encoder.sv - validates a region request and writes pmpaddr then pmpcfg
module pmp_napot_encoder
    import pmp_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_base,
    input  logic [5:0]  req_log2sz,
    input  logic [3:0]  req_entry,
    input  logic [2:0]  req_perm,
    input  logic        req_lock,
    output logic        csr_req,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    input  logic        csr_ack,
    output logic        rsp_valid,
    output logic [2:0]  rsp_err,
    input  logic        rsp_ready
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_e        state_q, state_d;
    err_e          err_q, err_d;
    logic [31:0]   base_q;
    logic [5:0]    log2sz_q;
    logic [3:0]    entry_q;
    logic [2:0]    perm_q;
    logic          lock_q;
    logic [CW-1:0] tmo_q;
    logic [7:0]    shadow_q [MAX_ENTRIES];

    logic [31:0]   trail_mask, align_mask, pmpaddr, cfg_word;
    logic [1:0]    a_field;
    logic [7:0]    new_cfg;
    logic          entry_bad, size_bad, locked, timeout, in_wr;

    napot_mask_gen u_mask (
        .log2sz     (log2sz_q),
        .trail_mask (trail_mask),
        .align_mask (align_mask)
    );

    always_comb begin
        entry_bad = int'({28'd0, entry_q}) >= NUM_ENTRIES;
        size_bad  = (log2sz_q < 6'd2) || (log2sz_q > 6'd32);
        locked    = shadow_q[entry_q][7];
        timeout   = tmo_q == CW'(TIMEOUT_CYC - 1);
        in_wr     = (state_q == WR_ADDR) || (state_q == WR_CFG);
        pmpaddr   = {2'b00, base_q[31:2]} | trail_mask;
        a_field   = (log2sz_q == 6'd2) ? A_NA4 : A_NAPOT;
        new_cfg   = cfg_byte(lock_q, a_field, perm_q);
        // The cfg CSR packs four entries; neighbours come from the shadow copy.
        for (int i = 0; i < 4; i++) begin
            cfg_word[8*i +: 8] = (entry_q[1:0] == 2'(i)) ? new_cfg
                                                         : shadow_q[{entry_q[3:2], 2'(i)}];
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) state_d = CHECK;
            CHECK: begin
                state_d = RESP;
                if (entry_bad)                           err_d = ENTRY;
                else if (locked)                         err_d = LOCK;
                else if (size_bad)                       err_d = SIZE;
                else if ((base_q & align_mask) != 32'd0) err_d = ALIGN;
                else if (perm_q[1] && !perm_q[0])        err_d = PERM;
                else begin
                    err_d   = OK;
                    state_d = WR_ADDR;
                end
            end
            WR_ADDR, WR_CFG: begin
                if (csr_ack) begin
                    state_d = (state_q == WR_ADDR) ? WR_CFG : RESP;
                end else if (timeout) begin
                    state_d = RESP;
                    err_d   = BUS;
                end
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = state_q == IDLE;
        csr_req   = in_wr;
        rsp_valid = state_q == RESP;
        rsp_err   = (state_q == RESP) ? err_q : OK;
        csr_addr  = 12'd0;
        csr_wdata = 32'd0;
        if (state_q == WR_ADDR) begin
            csr_addr  = PMPADDR_BASE + {8'd0, entry_q};
            csr_wdata = pmpaddr;
        end else if (state_q == WR_CFG) begin
            csr_addr  = PMPCFG_BASE + {10'd0, entry_q[3:2]};
            csr_wdata = cfg_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            err_q    <= OK;
            base_q   <= 32'd0;
            log2sz_q <= 6'd0;
            entry_q  <= 4'd0;
            perm_q   <= 3'd0;
            lock_q   <= 1'b0;
            tmo_q    <= '0;
            for (int i = 0; i < MAX_ENTRIES; i++) shadow_q[i] <= 8'd0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (state_q == IDLE && req_valid) begin
                base_q   <= req_base;
                log2sz_q <= req_log2sz;
                entry_q  <= req_entry;
                perm_q   <= req_perm;
                lock_q   <= req_lock;
            end
            // Restart the ack budget on every state change so each write gets its own.
            if (state_d != state_q) tmo_q <= '0;
            else if (in_wr)         tmo_q <= tmo_q + 1'b1;
            if (state_q == WR_CFG && csr_ack) shadow_q[entry_q] <= new_cfg;
        end
    end

endmodule
